// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Memory-access FSM encoding and the per-stage hold/bubble control bundle.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_bubble;
        logic ex_mem_write;
        logic mem_wb_bubble;
    } hold_ctrl_t;

    // Everything enabled, nothing squashed: the free-running pipeline.
    function automatic hold_ctrl_t run_ctrl();
        hold_ctrl_t c;
        c.pc_write      = 1'b1;
        c.if_id_write   = 1'b1;
        c.if_id_flush   = 1'b0;
        c.id_ex_bubble  = 1'b0;
        c.ex_mem_write  = 1'b1;
        c.mem_wb_bubble = 1'b0;
        return c;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status in, stage enables/strobes out.
// The controller takes the slave view; the pipeline/datapath takes the master view.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             ex_mem_memread_i;
    logic             ex_mem_memwrite_i;
    logic             mem_ack_i;
    logic             id_ex_memread_i;
    logic [4:0]       id_ex_rt_i;
    logic [4:0]       if_id_rs_i;
    logic [4:0]       if_id_rt_i;
    logic             branch_taken_i;

    logic             mem_req_o;
    logic             pc_write_o;
    logic             if_id_write_o;
    logic             if_id_flush_o;
    logic             id_ex_bubble_o;
    logic             ex_mem_write_o;
    logic             mem_wb_bubble_o;
    logic             err_o;
    logic [CNT_W-1:0] stall_cnt_o;

    modport master (
        output ex_mem_memread_i, ex_mem_memwrite_i, mem_ack_i,
               id_ex_memread_i, id_ex_rt_i, if_id_rs_i, if_id_rt_i, branch_taken_i,
        input  mem_req_o, pc_write_o, if_id_write_o, if_id_flush_o,
               id_ex_bubble_o, ex_mem_write_o, mem_wb_bubble_o, err_o, stall_cnt_o
    );

    modport slave (
        input  ex_mem_memread_i, ex_mem_memwrite_i, mem_ack_i,
               id_ex_memread_i, id_ex_rt_i, if_id_rs_i, if_id_rt_i, branch_taken_i,
        output mem_req_o, pc_write_o, if_id_write_o, if_id_flush_o,
               id_ex_bubble_o, ex_mem_write_o, mem_wb_bubble_o, err_o, stall_cnt_o
    );

endinterface

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Load-use hazard: the load in ID_EX writes a register the IF_ID instruction reads.
// Register zero never carries a dependency.
module pipe_hazard_ctrl_load_use_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic       id_ex_memread,
    input  logic [4:0] id_ex_rt,
    input  logic [4:0] if_id_rs,
    input  logic [4:0] if_id_rt,
    output logic       lu
);

    assign lu = id_ex_memread
              && (id_ex_rt != REG_ZERO)
              && ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: sequences data-memory
// req/ack, prioritises memory stall > load-use > taken branch, counts stall cycles.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 32
) (
    input logic               clk_i,
    input logic               rst_i,
    pipe_hazard_ctrl_if.slave hz
);

    localparam int               TMR_W    = $clog2(TIMEOUT) + 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_t           state;
    state_t           state_nxt;
    state_t           state_eff;
    logic [TMR_W-1:0] timer;
    logic [TMR_W-1:0] timer_nxt;
    logic [CNT_W-1:0] stall_cnt;

    logic       acc;
    logic       mstall;
    logic       mem_req;
    logic       err;
    logic       lu;
    hold_ctrl_t ctrl;

    pipe_hazard_ctrl_load_use_detect u_load_use_detect (
        .id_ex_memread (hz.id_ex_memread_i),
        .id_ex_rt      (hz.id_ex_rt_i),
        .if_id_rs      (hz.if_id_rs_i),
        .if_id_rt      (hz.if_id_rt_i),
        .lu            (lu)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            timer     <= '0;
            stall_cnt <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            if (mstall) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

    // While reset is asserted the outputs behave as IDLE with no access pending,
    // so a request in flight is dropped in the reset cycle itself.
    always_comb begin
        state_eff = rst_i ? IDLE : state;
        acc       = (hz.ex_mem_memread_i | hz.ex_mem_memwrite_i) & ~rst_i;
        state_nxt = state_eff;
        timer_nxt = timer;
        mstall    = 1'b0;
        mem_req   = 1'b0;
        err       = 1'b0;

        unique case (state_eff)
            IDLE: begin
                timer_nxt = '0;
                if (acc) begin
                    mstall    = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                mem_req = 1'b1;
                mstall  = 1'b1;
                if (hz.mem_ack_i) begin
                    state_nxt = DONE;
                    timer_nxt = '0;
                end else if (timer == TMR_LAST) begin
                    state_nxt = ERR;
                end else begin
                    timer_nxt = timer + TMR_W'(1);
                end
            end
            // Release cycle: the pipeline advances and the access leaves EX_MEM,
            // so returning to IDLE unconditionally never reissues it.
            DONE: begin
                state_nxt = IDLE;
            end
            ERR: begin
                mstall = 1'b1;
                err    = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Memory hold freezes IF_ID/ID_EX (ID_EX shares the EX_MEM enable), so
    // load-use and branch are simply re-evaluated once the stall releases.
    always_comb begin
        ctrl = run_ctrl();
        if (mstall) begin
            ctrl.pc_write      = 1'b0;
            ctrl.if_id_write   = 1'b0;
            ctrl.ex_mem_write  = 1'b0;
            ctrl.mem_wb_bubble = 1'b1;
        end else if (lu) begin
            ctrl.pc_write     = 1'b0;
            ctrl.if_id_write  = 1'b0;
            ctrl.id_ex_bubble = 1'b1;
        end else if (hz.branch_taken_i) begin
            ctrl.if_id_flush = 1'b1;
        end
    end

    assign hz.mem_req_o       = mem_req;
    assign hz.err_o           = err;
    assign hz.stall_cnt_o     = stall_cnt;
    assign hz.pc_write_o      = ctrl.pc_write;
    assign hz.if_id_write_o   = ctrl.if_id_write;
    assign hz.if_id_flush_o   = ctrl.if_id_flush;
    assign hz.id_ex_bubble_o  = ctrl.id_ex_bubble;
    assign hz.ex_mem_write_o  = ctrl.ex_mem_write;
    assign hz.mem_wb_bubble_o = ctrl.mem_wb_bubble;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed test-plan scenarios, then randomized traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_pipe_hazard_ctrl;

    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 32;

    // Reference-model view of the memory access lifecycle.
    localparam int FREE      = 0;
    localparam int ASKING    = 1;
    localparam int RELEASING = 2;
    localparam int DEAD      = 3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

    pipe_hazard_ctrl #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .hz    (hz)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int               m_phase;
    int               m_waited;
    logic [CNT_W-1:0] m_cnt;

    // {mem_req, pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_write, mem_wb_bubble, err}
    logic [7:0]       obs_v;
    logic [CNT_W-1:0] obs_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs against the model, advance the model.
    task automatic cyc(input bit r, input bit mr, input bit mw, input bit ack, input bit idmr,
                       input logic [4:0] idrt, input logic [4:0] rs, input logic [4:0] ifrt,
                       input bit br);
        bit         acc;
        bit         mstall;
        bit         lu;
        logic [7:0] exp_v;
        @(negedge clk);
        rst                  = r;
        hz.ex_mem_memread_i  = mr;
        hz.ex_mem_memwrite_i = mw;
        hz.mem_ack_i         = ack;
        hz.id_ex_memread_i   = idmr;
        hz.id_ex_rt_i        = idrt;
        hz.if_id_rs_i        = rs;
        hz.if_id_rt_i        = ifrt;
        hz.branch_taken_i    = br;
        #1;
        acc    = (mr || mw) && !r;
        mstall = !r && (m_phase == ASKING || m_phase == DEAD || (m_phase == FREE && acc));
        lu     = idmr && (idrt != 5'd0) && (idrt == rs || idrt == ifrt);
        exp_v    = 8'b0110_0100;
        exp_v[7] = !r && (m_phase == ASKING);
        exp_v[0] = !r && (m_phase == DEAD);
        if (mstall)  exp_v[6:1] = 6'b000001;
        else if (lu) exp_v[6:1] = 6'b000110;
        else if (br) exp_v[6:1] = 6'b111010;

        obs_v   = {hz.mem_req_o, hz.pc_write_o, hz.if_id_write_o, hz.if_id_flush_o,
                   hz.id_ex_bubble_o, hz.ex_mem_write_o, hz.mem_wb_bubble_o, hz.err_o};
        obs_cnt = hz.stall_cnt_o;
        check("ctrl", {56'd0, obs_v}, {56'd0, exp_v});
        check("stall_cnt", {32'd0, obs_cnt}, {32'd0, m_cnt});

        if (r) begin
            m_phase  = FREE;
            m_waited = 0;
            m_cnt    = '0;
        end else begin
            if (mstall) m_cnt = m_cnt + 1;
            case (m_phase)
                FREE: if (acc) begin
                    m_phase  = ASKING;
                    m_waited = 0;
                end
                ASKING: begin
                    if (ack) m_phase = RELEASING;
                    else begin
                        m_waited++;
                        if (m_waited == TIMEOUT) m_phase = DEAD;
                    end
                end
                RELEASING: m_phase = FREE;
                default: ;
            endcase
        end
    endtask

    initial begin
        int req_hi;
        int exw_lo;
        int err_hi;

        rst                  = 1'b1;
        hz.ex_mem_memread_i  = 1'b0;
        hz.ex_mem_memwrite_i = 1'b0;
        hz.mem_ack_i         = 1'b0;
        hz.id_ex_memread_i   = 1'b0;
        hz.id_ex_rt_i        = 5'd0;
        hz.if_id_rs_i        = 5'd0;
        hz.if_id_rt_i        = 5'd0;
        hz.branch_taken_i    = 1'b0;
        repeat (2) @(posedge clk);
        m_phase  = FREE;
        m_waited = 0;
        m_cnt    = '0;

        // Reset state
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("reset_ctrl", {56'd0, obs_v}, 64'h64);

        // Load, ack on the third REQ cycle
        req_hi = 0; exw_lo = 0;
        for (int k = 0; k < 5; k++) begin
            cyc(0, 1, 0, (k == 3), 0, 0, 0, 0, 0);
            req_hi += int'(obs_v[7]);
            exw_lo += int'(!obs_v[2]);
        end
        check("done_enables", {61'd0, obs_v[6], obs_v[5], obs_v[2]}, 64'd7);
        check("load_req_cycles", 64'(req_hi), 64'd3);
        check("load_exw_low", 64'(exw_lo), 64'd4);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("load_stall_cnt", {32'd0, obs_cnt}, 64'd4);

        // Load-use, and the same with rt = 0
        cyc(0, 0, 0, 0, 1, 5, 5, 0, 0);
        check("lu_stall", {56'd0, obs_v}, 64'h0C);
        cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
        check("lu_rt0", {56'd0, obs_v}, 64'h64);

        // Taken branch, no hazards
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("branch_flush", {56'd0, obs_v}, 64'h74);

        // Memory stall concurrent with load-use and branch
        cyc(0, 1, 0, 0, 1, 5, 5, 0, 1);
        check("mem_over_lu_br", {56'd0, obs_v}, 64'h02);
        cyc(0, 1, 0, 1, 1, 5, 0, 5, 1);
        check("req_over_lu_br", {56'd0, obs_v}, 64'h82);
        cyc(0, 1, 0, 0, 1, 5, 0, 5, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Back-to-back accesses with immediate ack
        req_hi = 0;
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
        req_hi += int'(obs_v[7]);
        cyc(0, 1, 0, 1, 0, 0, 0, 0, 0);
        req_hi += int'(obs_v[7]);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
        check("b2b_done_no_req", 64'(obs_v[7]), 64'd0);
        req_hi += int'(obs_v[7]);
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);
        req_hi += int'(obs_v[7]);
        cyc(0, 0, 1, 1, 0, 0, 0, 0, 0);
        req_hi += int'(obs_v[7]);
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);
        req_hi += int'(obs_v[7]);
        check("b2b_req_cycles", 64'(req_hi), 64'd2);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Timeout with no ack, held until reset
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
        req_hi = 0; err_hi = 0;
        for (int k = 0; k < TIMEOUT; k++) begin
            cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
            req_hi += int'(obs_v[7]);
            err_hi += int'(obs_v[0]);
        end
        check("to_req_cycles", 64'(req_hi), 64'(TIMEOUT));
        check("to_no_early_err", 64'(err_hi), 64'd0);
        for (int k = 0; k < 4; k++) begin
            cyc(0, 1, 0, (k == 2), 1, 5, 5, 0, 1);
            check("err_hold", {56'd0, obs_v}, 64'h03);
        end
        check("err_stall_cnt", {32'd0, obs_cnt}, 64'(TIMEOUT + 4));
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
        check("err_reset_cycle", {56'd0, obs_v}, 64'h64);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("err_cleared_cnt", {32'd0, obs_cnt}, 64'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit rr;
            rr = ($urandom_range(0, 99) < 2) || (m_phase == DEAD && $urandom_range(0, 99) < 15);
            cyc(rr,
                $urandom_range(0, 99) < 30,
                $urandom_range(0, 99) < 30,
                $urandom_range(0, 99) < 25,
                $urandom_range(0, 99) < 50,
                5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)),
                $urandom_range(0, 99) < 30);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline; drives write enables and bubble/flush strobes for PC, IF_ID, ID_EX, EX_MEM and MEM_WB.
- Three hazard sources:
  - multi-cycle data-memory access via a req/ack handshake, sequenced by an FSM;
  - load-use hazard, detected combinationally;
  - taken-branch flush from ID.
- Also keeps a sticky timeout error and a memory-stall performance counter.

Parameters:
- TIMEOUT, 64: max REQ cycles without ack before entering ERR.
- CNT_W, 32: width of stall_cnt_o.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous reset, active-high.
- ex_mem_memread_i  in  1  MemRead of instruction in EX_MEM.
- ex_mem_memwrite_i  in  1  MemWrite of instruction in EX_MEM.
- mem_ack_i  in  1  data memory completed access.
- id_ex_memread_i  in  1  MemRead of instruction in ID_EX.
- id_ex_rt_i  in  5  destination Rt in ID_EX.
- if_id_rs_i  in  5  Rs field in IF_ID.
- if_id_rt_i  in  5  Rt field in IF_ID.
- branch_taken_i  in  1  taken branch/jump resolved in ID.
- mem_req_o  out  1  data memory request.
- pc_write_o  out  1  PC enable.
- if_id_write_o  out  1  IF_ID enable.
- if_id_flush_o  out  1  IF_ID load NOP.
- id_ex_bubble_o  out  1  ID_EX loads zero control.
- ex_mem_write_o  out  1  EX_MEM enable.
- mem_wb_bubble_o  out  1  MEM_WB loads zero WB control.
- err_o  out  1  sticky memory timeout.
- stall_cnt_o  out  CNT_W  count of memory-stall cycles.

Behaviour:
- FSM states: IDLE, REQ, DONE, ERR. All transitions occur on clk_i. rst_i=1 -> IDLE, timer=0, stall_cnt_o=0.
- IDLE:
  - acc = memread|memwrite.
  - acc=1 -> mstall=1, next REQ.
  - Otherwise mstall=0, stay IDLE.
- REQ:
  - mem_req_o=1, mstall=1, timer increments.
  - mem_ack_i=1 -> next DONE, timer=0.
  - timer==TIMEOUT-1 without ack -> next ERR.
- DONE:
  - mem_req_o=0, mstall=0; the pipeline advances this cycle.
  - Next state is unconditionally IDLE, so the same access is never reissued.
  - An access loaded into EX_MEM at this edge is therefore seen in IDLE next cycle.
- ERR:
  - mstall=1, err_o=1; exited only by rst_i.
- mem_req_o=1 only in REQ. err_o=1 only in ERR.
- stall_cnt_o increments every cycle mstall=1 and wraps at 2^CNT_W.
- Load-use hazard: lu = id_ex_memread_i & id_ex_rt_i!=0 & (id_ex_rt_i==if_id_rs_i | id_ex_rt_i==if_id_rt_i).
- Priority 1, mstall=1:
  - pc_write_o, if_id_write_o and ex_mem_write_o = 0.
  - if_id_flush_o = 0, id_ex_bubble_o = 0.
  - mem_wb_bubble_o = 1.
  - lu and branch are ignored; they are re-evaluated after release because IF_ID/ID_EX are frozen.
  - ID_EX enable = ex_mem_write_o.
- Priority 2, lu=1:
  - pc_write_o = 0, if_id_write_o = 0, id_ex_bubble_o = 1.
  - ex_mem_write_o = 1.
  - if_id_flush_o = 0, because the branch is re-evaluated next cycle.
- Priority 3, branch_taken_i=1:
  - if_id_flush_o = 1.
  - All write enables = 1.
- Default case: all enables = 1, all strobes = 0.
- Outputs are combinational from state and inputs; there is no added latency. Memory-access cost is 2 cycles plus ack wait.
- Reset mid-REQ: mem_req_o drops in the reset cycle. Outputs in the reset cycle take IDLE values with acc forced to 0.

Decomposition:
- Shared package: state encoding (2-bit, IDLE=0, REQ=1, DONE=2, ERR=3) and the REG_ZERO=5'd0 constant.
- One sub-module: load_use_detect (pure combinational lu equation).
- FSM, timer and counter stay in the top module.

Test Plan:
- Load with memread=1, ack after 3 REQ cycles:
  - mem_req_o high exactly 3 cycles.
  - ex_mem_write_o low 4 cycles.
  - DONE for 1 cycle with enables=1.
  - stall_cnt_o=4.
- id_ex_memread=1, id_ex_rt=5, if_id_rs=5:
  - pc_write_o=0, if_id_write_o=0, id_ex_bubble_o=1 for one cycle.
  - The same inputs with rt=0 give no stall.
- branch_taken_i=1 with no hazards -> if_id_flush_o=1 and all enables=1.
- Memory stall concurrent with lu and branch -> only the memory hold is active (flush=0, bubble=0, mem_wb_bubble_o=1).
- TIMEOUT=8, no ack:
  - err_o=1 after 8 REQ cycles.
  - Stall held indefinitely.
  - rst_i clears to IDLE, err_o=0, stall_cnt_o=0.
- Back-to-back loads with immediate ack: the second access begins REQ after DONE and the first address is never re-requested.
